// File: rtl/taillight_seq_if.sv
// Request/lamp bundle between the driver-input debouncers, the sequencer
// and the lamp output pins. The master side (debouncer/bench) drives the
// requests; the slave side (sequencer) drives the lamp banks and the tick.
interface taillight_seq_if #(
  parameter int LAMPS = 3
);
  logic             left_req;
  logic             right_req;
  logic             hazard;
  logic             brake;
  logic [LAMPS-1:0] left;
  logic [LAMPS-1:0] right;
  logic             tick;

  modport master (
    output left_req, right_req, hazard, brake,
    input  left, right, tick
  );

  modport slave (
    input  left_req, right_req, hazard, brake,
    output left, right, tick
  );
endinterface

// File: rtl/taillight_seq.sv
// Tail-light sequencer for both lamp banks: left/right turn fill, hazard
// flash and brake override, stepped by an internal power-of-two divider.
module taillight_seq #(
  parameter int LAMPS = 3,
  parameter int DIV_W = 26
) (
  input  logic            clk,
  input  logic            rst,
  taillight_seq_if.slave  bus
);

  localparam int STEP_W = $clog2(LAMPS + 1);
  localparam logic [LAMPS:0]      FILL_ONE = (LAMPS + 1)'(1);
  localparam logic [STEP_W-1:0]   STEP_ONE = STEP_W'(1);
  localparam logic [STEP_W-1:0]   STEP_MAX = STEP_W'(LAMPS);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  logic [DIV_W-1:0]  div;
  logic              tick;
  mode_t             mode;
  mode_t             req_mode;
  logic [STEP_W-1:0] step;
  logic              brake_q;
  logic [LAMPS-1:0]  left_bank;
  logic [LAMPS-1:0]  right_bank;

  // Next position in the sequence for the current mode. LEFT/RIGHT run
  // 0..LAMPS (the extra position is the dark gap), HAZARD toggles 0/1.
  function automatic logic [STEP_W-1:0] next_step(input mode_t m,
                                                  input logic [STEP_W-1:0] s);
    case (m)
      LEFT, RIGHT: next_step = (s == STEP_MAX) ? '0 : s + STEP_ONE;
      HAZARD:      next_step = {{(STEP_W-1){1'b0}}, ~s[0]};
      default:     next_step = '0;
    endcase
  endfunction

  // Thermometer fill from the inner lamp: step lamps lit, (1<<step)-1.
  // Computed one bit wider so step == LAMPS lights the whole bank.
  function automatic logic [LAMPS-1:0] lamp_fill(input logic [STEP_W-1:0] s);
    logic [LAMPS:0] t;
    t = (FILL_ONE << s) - FILL_ONE;
    lamp_fill = t[LAMPS-1:0];
  endfunction

  // Step strobe: the last count of the divider.
  assign tick = (div == {DIV_W{1'b1}});

  // Request decode: hazard, or both turn requests together, wins.
  always_comb begin
    req_mode = IDLE;
    if (bus.hazard || (bus.left_req && bus.right_req)) begin
      req_mode = HAZARD;
    end else if (bus.left_req) begin
      req_mode = LEFT;
    end else if (bus.right_req) begin
      req_mode = RIGHT;
    end
  end

  // Free-running divider; deliberately not cleared on a mode change.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else begin
      div <= div + DIV_ONE;
    end
  end

  // Mode/step state machine plus the brake sample. A mode change restarts
  // the sequence at step 0 and takes precedence over a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= IDLE;
      step    <= '0;
      brake_q <= 1'b0;
    end else begin
      brake_q <= bus.brake;
      mode    <= req_mode;
      if (req_mode != mode) begin
        step <= '0;
      end else if (tick) begin
        step <= next_step(mode, step);
      end
    end
  end

  // Lamp decode from registered state; hazard flashing ignores the brake.
  always_comb begin
    left_bank  = brake_q ? '1 : '0;
    right_bank = brake_q ? '1 : '0;
    case (mode)
      LEFT: begin
        left_bank = lamp_fill(step);
      end
      RIGHT: begin
        right_bank = lamp_fill(step);
      end
      HAZARD: begin
        left_bank  = step[0] ? '1 : '0;
        right_bank = step[0] ? '1 : '0;
      end
      default: begin
      end
    endcase
  end

  assign bus.left  = left_bank;
  assign bus.right = right_bank;
  assign bus.tick  = tick;

endmodule

// File: tb/tb_taillight_seq.sv
// Bench for taillight_seq: a 3-lamp and a 5-lamp instance with DIV_W=2.
// Directed vectors push their expected lamp/tick values into a scoreboard
// queue; a monitor on the falling edge pops and compares.
module tb_taillight_seq;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  taillight_seq_if #(.LAMPS(3)) ifa ();
  taillight_seq_if #(.LAMPS(5)) ifb ();

  taillight_seq #(.LAMPS(3), .DIV_W(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa.slave)
  );

  taillight_seq #(.LAMPS(5), .DIV_W(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb.slave)
  );

  typedef struct {
    int         cyc;
    int         dut;
    int         idx;
    logic [7:0] el;
    logic [7:0] er;
    logic       et;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int idx,
                     input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec %0d: got %b, expected %b", name, idx, got, want);
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] gl, gr;
    logic gt;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed vec %0d: due cycle %0d, now %0d", e.idx, e.cyc, cyc);
      end else begin
        if (e.dut == 0) begin
          gl = {5'b0, ifa.left};
          gr = {5'b0, ifa.right};
          gt = ifa.tick;
        end else begin
          gl = {3'b0, ifb.left};
          gr = {3'b0, ifb.right};
          gt = ifb.tick;
        end
        chk(e.dut == 0 ? "a.left"  : "b.left",  e.idx, gl, e.el);
        chk(e.dut == 0 ? "a.right" : "b.right", e.idx, gr, e.er);
        chk(e.dut == 0 ? "a.tick"  : "b.tick",  e.idx, {7'b0, gt}, {7'b0, e.et});
      end
    end
  end

  // Apply one input vector to instance A for the next rising edge and
  // record what the outputs must read after that edge.
  task automatic va(input bit rs, input bit l, input bit r, input bit h,
                    input bit b, input int el, input int er, input bit et);
    exp_t e;
    rst_a         = rs;
    ifa.left_req  = l;
    ifa.right_req = r;
    ifa.hazard    = h;
    ifa.brake     = b;
    e.cyc = cyc + 1;
    e.dut = 0;
    e.idx = vec_idx;
    e.el  = 8'(el);
    e.er  = 8'(er);
    e.et  = et;
    sbq.push_back(e);
    vec_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic vb(input bit rs, input bit r, input int el, input int er,
                    input bit et);
    exp_t e;
    rst_b         = rs;
    ifb.left_req  = 1'b0;
    ifb.right_req = r;
    ifb.hazard    = 1'b0;
    ifb.brake     = 1'b0;
    e.cyc = cyc + 1;
    e.dut = 1;
    e.idx = vec_idx;
    e.el  = 8'(el);
    e.er  = 8'(er);
    e.et  = et;
    sbq.push_back(e);
    vec_idx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] pats [7];
    pats = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000};

    ifb.left_req  = 1'b0;
    ifb.right_req = 1'b0;
    ifb.hazard    = 1'b0;
    ifb.brake     = 1'b0;

    //  rst l r h b   L  R  T     -- LEFT fill, request held through reset
    va(1, 1, 0, 0, 0, 0, 0, 0);
    va(0, 1, 0, 0, 0, 0, 0, 0);
    va(0, 1, 0, 0, 0, 0, 0, 0);
    va(0, 1, 0, 0, 0, 0, 0, 1);
    va(0, 1, 0, 0, 0, 1, 0, 0);
    va(0, 1, 0, 0, 0, 1, 0, 0);
    va(0, 1, 0, 0, 0, 1, 0, 0);
    va(0, 1, 0, 0, 0, 1, 0, 1);
    va(0, 1, 0, 0, 0, 3, 0, 0);
    va(0, 1, 0, 0, 0, 3, 0, 0);
    va(0, 1, 0, 0, 0, 3, 0, 0);
    va(0, 1, 0, 0, 0, 3, 0, 1);
    va(0, 1, 0, 0, 0, 7, 0, 0);
    va(0, 1, 0, 0, 0, 7, 0, 0);
    va(0, 1, 0, 0, 0, 7, 0, 0);
    va(0, 1, 0, 0, 0, 7, 0, 1);
    va(0, 1, 0, 0, 0, 0, 0, 0);
    // brake with LEFT, then drop left_req
    va(0, 1, 0, 0, 1, 0, 7, 0);
    va(0, 1, 0, 0, 1, 0, 7, 0);
    va(0, 1, 0, 0, 1, 0, 7, 1);
    va(0, 1, 0, 0, 1, 1, 7, 0);
    va(0, 0, 0, 0, 1, 7, 7, 0);
    va(0, 0, 0, 0, 0, 0, 0, 0);
    // hazard via both requests, then brake added
    va(0, 1, 1, 0, 0, 0, 0, 1);
    va(0, 1, 1, 0, 0, 7, 7, 0);
    va(0, 1, 1, 0, 0, 7, 7, 0);
    va(0, 1, 1, 0, 0, 7, 7, 0);
    va(0, 1, 1, 0, 0, 7, 7, 1);
    va(0, 1, 1, 0, 0, 0, 0, 0);
    va(0, 1, 1, 0, 1, 0, 0, 0);
    va(0, 1, 1, 0, 1, 0, 0, 0);
    va(0, 1, 1, 0, 1, 0, 0, 1);
    va(0, 1, 1, 0, 1, 7, 7, 0);
    // reset mid-hazard, hazard restarts from step 0
    va(1, 1, 1, 0, 1, 0, 0, 0);
    va(0, 1, 1, 0, 1, 0, 0, 0);
    va(0, 1, 1, 0, 1, 0, 0, 0);
    va(0, 1, 1, 0, 1, 0, 0, 1);
    va(0, 1, 1, 0, 1, 7, 7, 0);
    // LEFT to step 2, then switch to RIGHT on a tick clock
    va(0, 1, 0, 0, 0, 0, 0, 0);
    va(0, 1, 0, 0, 0, 0, 0, 0);
    va(0, 1, 0, 0, 0, 0, 0, 1);
    va(0, 1, 0, 0, 0, 1, 0, 0);
    va(0, 1, 0, 0, 0, 1, 0, 0);
    va(0, 1, 0, 0, 0, 1, 0, 0);
    va(0, 1, 0, 0, 0, 1, 0, 1);
    va(0, 1, 0, 0, 0, 3, 0, 0);
    va(0, 1, 0, 0, 0, 3, 0, 0);
    va(0, 1, 0, 0, 0, 3, 0, 0);
    va(0, 1, 0, 0, 0, 3, 0, 1);
    va(0, 0, 1, 0, 0, 0, 0, 0);
    va(0, 0, 1, 0, 0, 0, 0, 0);
    va(0, 0, 1, 0, 0, 0, 0, 0);
    va(0, 0, 1, 0, 0, 0, 0, 1);
    va(0, 0, 1, 0, 0, 0, 1, 0);
    // idle, then the hazard pin on its own
    va(0, 0, 0, 0, 0, 0, 0, 0);
    va(0, 0, 0, 1, 0, 0, 0, 0);
    va(0, 0, 0, 1, 0, 0, 0, 1);
    va(0, 0, 0, 1, 0, 7, 7, 0);
    va(0, 0, 0, 0, 0, 0, 0, 0);

    // 5-lamp instance: RIGHT held for six ticks
    for (int e = 0; e <= 24; e++) begin
      vb(e == 0, 1'b1, 0, int'(pats[e / 4]), (e % 4) == 3);
    end
    vb(0, 1'b0, 0, 0, 0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/taillight_seq.md
Name: taillight_seq

Overview:
- Parametrised tail-light sequencer that drives both the left and right lamp banks from a single block.
- Supports four modes: left turn, right turn, hazard and brake override, with a configurable lamp count per side.
- Generates its own step tick from the system clock using an internal divider.
- Sits between the driver-input debouncers and the lamp output pins, and supersedes the single-side, fixed 3-lamp sequencer.

Parameters:
- LAMPS, 3: lamps per side; legal range 2..8.
- DIV_W, 26: divider width. The step tick period is 2^DIV_W clocks. Benches use DIV_W=2, giving a tick every 4 clocks.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- left_req  input  1  left turn request, level-sensitive.
- right_req  input  1  right turn request, level-sensitive.
- hazard  input  1  hazard request, level-sensitive.
- brake  input  1  brake pedal, level-sensitive.
- Left  output  LAMPS  left lamp bank; bit 0 is the innermost lamp.
- Right  output  LAMPS  right lamp bank; bit 0 is the innermost lamp.
- tick  output  1  one-cycle step strobe, exposed for debug and test.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high (Rst); there is no asynchronous path.
- Reset values:
  - div = 0, mode = IDLE, step = 0, brake_q = 0.
  - Left = 0, Right = 0, tick = 0.
  - All outputs must read these values in the first cycle after Rst is sampled high.
- Divider:
  - DIV_W-bit free-running counter; increments every clock and wraps to 0.
  - tick = 1 exactly when div == 2^DIV_W-1, decoded combinationally from the div register.
  - With DIV_W=2, tick is high in clocks 3, 7, 11, ... after Rst deasserts (clock 0 = first clock out of reset).
- Requested mode, decoded each clock in priority order:
  - hazard = 1, or left_req and right_req both = 1 → HAZARD.
  - otherwise left_req → LEFT.
  - otherwise right_req → RIGHT.
  - otherwise → IDLE.
- Mode register:
  - mode loads the requested mode on every clock.
  - When the requested mode differs from the current mode, step is cleared to 0 on that same edge.
  - A mode change never advances step, even when tick is also high (change wins).
  - div is NOT cleared on a mode change, so the first step of a new mode lasts 1..2^DIV_W clocks.
- Step counter: range 0..LAMPS.
  - Advances only on a clock where tick = 1 and the mode is unchanged.
  - LEFT/RIGHT: step = step == LAMPS ? 0 : step+1.
  - HAZARD: step toggles between 0 and 1.
  - IDLE: step is held at 0.
- brake_q is registered from brake every clock, so brake has 1-clock latency to the lamps.
- Lamp decode (combinational from registered mode, step and brake_q):
  - LEFT: Left = (1<<step)-1, so the bank fills from the inner lamp outward, then goes dark. Right = brake_q ? all-ones : 0.
  - RIGHT: mirror of LEFT.
  - HAZARD: Left = Right = step[0] ? all-ones : 0. Brake is ignored, because hazard flashing has priority.
  - IDLE: Left = Right = brake_q ? all-ones : 0.
- Sequence period:
  - LEFT/RIGHT: LAMPS+1 ticks per cycle.
  - HAZARD: 2 ticks per period.
- Reset mid-sequence: all state is cleared on the next edge regardless of mode or inputs. Requests held high through reset take effect in clock 0 after release.
- Requests dropping mid-sequence: on the next edge the mode becomes IDLE and the lamps go to the IDLE decode immediately; the current sequence is not completed.

Test Plan:
- Test 1, LEFT fill sequence. Parameters DIV_W=2, LAMPS=3. Stimulus: Rst pulse, then left_req=1 held. Required response: Left steps 000 → 001 → 011 → 111 → 000, changing one clock after each tick. Right=000 throughout. tick is high in clocks 3, 7, 11, 15.
- Test 2, brake with LEFT. Stimulus: left_req=1 and brake=1 together. Required response: Right=111 from the 2nd clock onward while Left continues its sequence. Then release left_req only: both banks read 111 one clock later.
- Test 3, hazard via both requests. Stimulus: left_req=right_req=1. Required response: Left=Right, alternating 000/111 on every tick. Adding brake=1 does not change the pattern.
- Test 4, mode change mid-sequence. Stimulus: LEFT at step 2 (Left=011), then switch to right_req only on a tick clock. Required response: next cycle Left=000, Right=000 (step=0, no advance). Right then fills 001 on the following tick.
- Test 5, reset mid-operation. Stimulus: assert Rst for 1 clock during HAZARD with lamps on. Required response: the next cycle reads Left=Right=0, tick=0, div=0. The hazard pattern restarts from step 0 once Rst deasserts.
- Test 6, LAMPS=5 regression. Stimulus: RIGHT held for 6 ticks. Required response: Right sequence 00000 → 00001 → 00011 → 00111 → 01111 → 11111 → 00000.
